// File: rtl/usb2_ep_writer.sv
// Client-side producer for the double-buffered USB 2.0 endpoint: streams bytes into the
// current buffer half, then commits it. Optional ZLP after a full last packet: USB2_EP_WRITER_ZLP_EN.
module usb2_ep_writer #(
  parameter int MAX_PKT = 512,
  parameter int CNT_W   = 16
) (
  input  logic             wr_clk,
  input  logic             reset_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [8:0]       buf_in_addr,
  output logic [7:0]       buf_in_data,
  output logic             buf_in_wren,
  input  logic             buf_in_ready,
  output logic             buf_in_commit,
  output logic [9:0]       buf_in_commit_len,
  input  logic             buf_in_commit_ack,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [1:0] {WAIT_RDY, FILL, COMMIT, ACK_LO} state_t;

  localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

  state_t           state_q, state_d;
  logic [1:0]       settle_q, settle_d;
  logic [9:0]       count_q, count_d;
  logic [8:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wren_q, wren_d;
  logic [9:0]       len_q, len_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic             rdy_meta_q, rdy_s_q;
  logic             ack_meta_q, ack_s_q;
  logic [9:0]       count_inc;
`ifdef USB2_EP_WRITER_ZLP_EN
  logic             zlp_pend_q, zlp_pend_d;
`endif

  assign count_inc = count_q + 10'd1;

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_RDY;
      settle_q    <= 2'd0;
      count_q     <= 10'd0;
      addr_q      <= 9'd0;
      data_q      <= 8'd0;
      wren_q      <= 1'b0;
      len_q       <= 10'd0;
      pkt_count_q <= '0;
      rdy_meta_q  <= 1'b0;
      rdy_s_q     <= 1'b0;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
`ifdef USB2_EP_WRITER_ZLP_EN
      zlp_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      len_q       <= len_d;
      pkt_count_q <= pkt_count_d;
      rdy_meta_q  <= buf_in_ready;
      rdy_s_q     <= rdy_meta_q;
      ack_meta_q  <= buf_in_commit_ack;
      ack_s_q     <= ack_meta_q;
`ifdef USB2_EP_WRITER_ZLP_EN
      zlp_pend_q  <= zlp_pend_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    count_d     = count_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    len_d       = len_q;
    pkt_count_d = pkt_count_q;
`ifdef USB2_EP_WRITER_ZLP_EN
    zlp_pend_d  = zlp_pend_q;
`endif
    case (state_q)
      WAIT_RDY: begin
        // Ready seen right after a swap may still describe the old half; let it settle.
        if (settle_q != 2'd2) begin
          settle_d = settle_q + 2'd1;
        end else if (rdy_s_q) begin
`ifdef USB2_EP_WRITER_ZLP_EN
          if (zlp_pend_q) begin
            state_d    = COMMIT;
            len_d      = 10'd0;
            zlp_pend_d = 1'b0;
          end else begin
            state_d = FILL;
          end
`else
          state_d = FILL;
`endif
        end
      end
      FILL: begin
        if (s_valid) begin
          wren_d = 1'b1;
          addr_d = count_q[8:0];
          data_d = s_data;
          if ((count_inc == MAX_LEN) || s_last) begin
            len_d   = count_inc;
            count_d = 10'd0;
            state_d = COMMIT;
`ifdef USB2_EP_WRITER_ZLP_EN
            zlp_pend_d = s_last && (count_inc == MAX_LEN);
`endif
          end else begin
            count_d = count_inc;
          end
        end
      end
      COMMIT: begin
        if (ack_s_q) state_d = ACK_LO;
      end
      ACK_LO: begin
        if (!ack_s_q) begin
          pkt_count_d = pkt_count_q + CNT_W'(1);
          settle_d    = 2'd0;
          state_d     = WAIT_RDY;
        end
      end
      default: state_d = WAIT_RDY;
    endcase
  end

  always_comb begin
    s_ready           = (state_q == FILL);
    buf_in_commit     = (state_q == COMMIT);
    busy              = !((state_q == FILL) && (count_q == 10'd0));
    buf_in_addr       = addr_q;
    buf_in_data       = data_q;
    buf_in_wren       = wren_q;
    buf_in_commit_len = len_q;
    pkt_count         = pkt_count_q;
  end

endmodule
